// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time imem loader: state encodings,
// frame marker default and frame field widths.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         BYTE_W            = 8;
    localparam int         WORD_W            = 32;
    localparam int         LEN_W             = 16;

endpackage

// File: rtl/imem_loader_wpack.sv
// Packs accepted bytes into little-endian 32-bit words and keeps the running
// XOR of every byte seen since the last clear.
module imem_loader_wpack
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              clr,
    output logic [WORD_W-1:0] word_out,
    output logic              word_rdy,
    output logic [BYTE_W-1:0] xor_out,
    output logic [1:0]        byte_idx
);

    logic [23:0] shreg;

    // Bytes enter at the top and shift down, so the first byte lands in lane 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            byte_idx <= '0;
            xor_out  <= '0;
            word_out <= '0;
            word_rdy <= 1'b0;
        end else begin
            word_rdy <= 1'b0;
            if (clr) begin
                shreg    <= '0;
                byte_idx <= '0;
                xor_out  <= '0;
            end else if (byte_en) begin
                xor_out  <= xor_out ^ byte_in;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    word_out <= {byte_in, shreg};
                    word_rdy <= 1'b1;
                    shreg    <= '0;
                end else begin
                    shreg <= {byte_in, shreg[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC/LEN/DATA/CSUM frames from a byte stream, writes
// packed words into imem and holds the core in reset until the frame checks out.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 12,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       MAX_WORDS = 32'(2 ** ADDR_WIDTH);

    // Handshake semantics: a byte transfers on a rising clk edge where
    // in_valid & in_ready are both high; in_ready comes from registered state only.
    state_t                state, state_n;
    logic                  hs, timed, tmo, last_word;
    logic [7:0]            len_lo;
    logic [LEN_W-1:0]      len_n, nwords;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic [TCNT_W-1:0]     tcnt;
    logic                  byte_en, clr, word_rdy;
    logic [1:0]            byte_idx;
    logic [7:0]            xor_out;
    logic [31:0]           word_out;

    assign in_ready   = (state != ST_DONE);
    assign hs         = in_valid & in_ready;
    assign len_n      = {in_data, len_lo};
    assign timed      = (state == ST_LEN0) || (state == ST_LEN1) ||
                        (state == ST_DATA) || (state == ST_CSUM);
    assign tmo        = (tcnt == TCNT_LAST);
    assign last_word  = (LEN_W'(wcnt) == nwords - 16'd1);
    assign byte_en    = hs && (state == ST_DATA) && !start;
    assign clr        = start || (hs && (state == ST_LEN1));
    assign imem_we    = word_rdy;
    assign imem_wdata = word_out;
    assign imem_addr  = wcnt;
    assign done       = (state == ST_DONE);
    assign err        = (state == ST_ERR);
    assign dbg_state  = state;

    imem_loader_wpack u_wpack (
        .clk      (clk),
        .rst      (rst),
        .byte_en  (byte_en),
        .byte_in  (in_data),
        .clr      (clr),
        .word_out (word_out),
        .word_rdy (word_rdy),
        .xor_out  (xor_out),
        .byte_idx (byte_idx)
    );

    always_comb begin
        state_n = state;
        if (start) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (hs && in_data == SYNC_BYTE) state_n = ST_LEN0;
                ST_LEN0: begin
                    if (hs)       state_n = ST_LEN1;
                    else if (tmo) state_n = ST_ERR;
                end
                ST_LEN1: begin
                    if (hs) begin
                        if ({16'd0, len_n} > MAX_WORDS) state_n = ST_ERR;
                        else if (len_n == '0)           state_n = ST_CSUM;
                        else                            state_n = ST_DATA;
                    end else if (tmo) begin
                        state_n = ST_ERR;
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        if (byte_idx == 2'd3 && last_word) state_n = ST_CSUM;
                    end else if (tmo) begin
                        state_n = ST_ERR;
                    end
                end
                ST_CSUM: begin
                    if (hs)       state_n = (in_data == xor_out) ? ST_DONE : ST_ERR;
                    else if (tmo) state_n = ST_ERR;
                end
                ST_DONE: state_n = ST_DONE;
                ST_ERR:  if (hs && in_data == SYNC_BYTE) state_n = ST_LEN0;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // The core is released one cycle after DONE is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            len_lo     <= '0;
            nwords     <= '0;
            wcnt       <= '0;
            tcnt       <= '0;
            core_rst_n <= 1'b0;
        end else begin
            state      <= state_n;
            core_rst_n <= !start && (state == ST_DONE);
            if (start) begin
                len_lo <= '0;
                nwords <= '0;
                wcnt   <= '0;
                tcnt   <= '0;
            end else begin
                if (hs && state == ST_LEN0) len_lo <= in_data;
                if (hs && state == ST_LEN1) begin
                    nwords <= len_n;
                    wcnt   <= '0;
                end else if (word_rdy) begin
                    wcnt <= wcnt + 1'b1;
                end
                if (hs || !timed) tcnt <= '0;
                else              tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame vector table plus hand-written
// sequences for retry, timeout, start abort, async reset and stalled loads.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW = 4;
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, imem_we, core_rst_n, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [2:0]    dbg_state;

    imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    int             checks = 0;
    int             errors = 0;
    logic [AW+31:0] exp_q[$];
    logic [31:0]    mem_model [2**AW];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every imem write must match the head of the expected queue
    always @(negedge clk) begin
        if (rst && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", imem_addr, imem_wdata);
            end else begin
                chk("imem_write", 64'({imem_addr, imem_wdata}), 64'(exp_q.pop_front()));
            end
            mem_model[imem_addr] = imem_wdata;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_write(input int a, input logic [31:0] d);
        exp_q.push_back({AW'(a), d});
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int   guard;
        int   gap;
        logic acc;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
        end
        guard    = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            acc = in_ready;
            tick();
            guard++;
        end while (!acc && guard < 50);
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
    endtask

    typedef struct {
        string      name;
        int         n;
        logic [7:0] b [16];
        int         nw;
        logic [31:0] w [2];
        logic       exp_done;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] words [16];
    logic [7:0]  csum;

    initial begin
        // Payload 13 00 00 00 93 00 10 00 -> XOR checksum 0x90.
        vecs[0].name = "good";
        vecs[0].n = 12;
        vecs[0].b = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93,
                      8'h00, 8'h10, 8'h00, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[0].nw = 2;
        vecs[0].w = '{32'h00000013, 32'h00100093};
        vecs[0].exp_done = 1'b1;

        vecs[1] = vecs[0];
        vecs[1].name = "bad_csum";
        vecs[1].b[11] = 8'h95;
        vecs[1].exp_done = 1'b0;

        vecs[2].name = "junk_len0";
        vecs[2].n = 6;
        vecs[2].b = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].nw = 0;
        vecs[2].w = '{32'h0, 32'h0};
        vecs[2].exp_done = 1'b1;

        vecs[3] = vecs[2];
        vecs[3].name = "len_too_big";
        vecs[3].n = 3;
        vecs[3].b[0] = 8'hA5;
        vecs[3].b[1] = 8'h11;
        vecs[3].b[2] = 8'h00;
        vecs[3].exp_done = 1'b0;

        // reset values
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        tick();

        // table-driven frames
        for (int i = 0; i < 4; i++) begin
            pulse_start();
            chk({vecs[i].name, "_pre_done"}, done, 0);
            chk({vecs[i].name, "_pre_err"}, err, 0);
            for (int k = 0; k < vecs[i].nw; k++) push_write(k, vecs[i].w[k]);
            for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k], 0);
            chk({vecs[i].name, "_done"}, done, vecs[i].exp_done);
            chk({vecs[i].name, "_err"}, err, !vecs[i].exp_done);
            chk({vecs[i].name, "_core_rst_n_now"}, core_rst_n, 0);
            chk({vecs[i].name, "_in_ready"}, in_ready, !vecs[i].exp_done);
            tick();
            chk({vecs[i].name, "_core_rst_n_next"}, core_rst_n, vecs[i].exp_done);
            chk({vecs[i].name, "_writes_drained"}, exp_q.size(), 0);
        end

        // bad checksum, then retry from ERR with SYNC and no start pulse
        pulse_start();
        for (int k = 0; k < 2; k++) push_write(k, vecs[0].w[k]);
        for (int k = 0; k < 12; k++) send_byte(vecs[1].b[k], 0);
        chk("retry_err", err, 1);
        tick();
        chk("retry_core_held", core_rst_n, 0);
        for (int k = 0; k < 2; k++) push_write(k, vecs[0].w[k]);
        send_byte(8'hA5, 0);
        chk("retry_err_cleared", err, 0);
        for (int k = 1; k < 12; k++) send_byte(vecs[0].b[k], 0);
        chk("retry_done", done, 1);
        tick();
        chk("retry_core_released", core_rst_n, 1);

        // timeout after LEN_HI
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        repeat (TO - 1) tick();
        chk("timeout_not_yet", err, 0);
        tick();
        chk("timeout_err", err, 1);
        chk("timeout_state", dbg_state, ST_ERR);

        // start during DATA drops the concurrent byte and returns to IDLE
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("abort_state", dbg_state, ST_IDLE);
        chk("abort_err", err, 0);
        chk("abort_core_rst_n", core_rst_n, 0);
        for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
        chk("abort_still_idle", dbg_state, ST_IDLE);
        chk("abort_done", done, 0);

        // async reset mid-DATA, after one word has been written
        pulse_start();
        push_write(0, 32'h44332211);
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        chk("pre_arst_addr", imem_addr, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_imem_addr", imem_addr, 0);
        chk("arst_imem_wdata", imem_wdata, 0);
        chk("arst_core_rst_n", core_rst_n, 0);
        chk("arst_state", dbg_state, ST_IDLE);
        chk("arst_err", err, 0);
        #2 rst = 1'b1;
        tick();

        // maximum-size image, without and then with random stalls
        csum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            words[i] = $urandom;
            csum = csum ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
        end
        for (int run = 0; run < 2; run++) begin
            for (int i = 0; i < 16; i++) mem_model[i] = 32'hDEADBEEF;
            pulse_start();
            for (int i = 0; i < 16; i++) push_write(i, words[i]);
            send_byte(8'hA5, run * 3);
            send_byte(8'h10, run * 3);
            send_byte(8'h00, run * 3);
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 4; j++) begin
                    send_byte(words[i][8*j +: 8], run * 3);
                end
            end
            send_byte(csum, run * 3);
            chk("max_done", done, 1);
            chk("max_err", err, 0);
            for (int i = 0; i < 16; i++) chk("max_mem", mem_model[i], words[i]);
        end

        tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
